// File: rtl/axi_node_pkg.sv
// Shared AXI node types and constants used by the AW decoder and its
// region matcher.
package axi_node_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ERR_DRAIN = 2'd1,
        ERR_DATA  = 2'd2,
        ERR_RESP  = 2'd3
    } aw_dec_state_t;

endpackage

// File: rtl/axi_region_match.sv
// Address region comparator bank for one master port: reports a hit when the
// address falls inside any enabled inclusive region and the port is reachable.
module axi_region_match #(
    parameter int ADDR_WIDTH = 32,
    parameter int N_REGION   = 2
) (
    input  logic [ADDR_WIDTH-1:0]          addr_i,
    input  logic [N_REGION*ADDR_WIDTH-1:0] start_addr_i,
    input  logic [N_REGION*ADDR_WIDTH-1:0] end_addr_i,
    input  logic [N_REGION-1:0]            enable_region_i,
    input  logic                           connected_i,
    output logic                           match_o
);

    logic region_hit;

    always_comb begin
        region_hit = 1'b0;
        for (int r = 0; r < N_REGION; r++) begin
            if (enable_region_i[r] &&
                (addr_i >= start_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (addr_i <= end_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
                region_hit = 1'b1;
            end
        end
        match_o = connected_i & region_hit;
    end

endmodule

// File: rtl/axi_aw_decoder_dest_push.sv
// AW-channel decoder for one slave port: steers AW to the matched master port,
// pushes the one-hot destination, and absorbs unmapped writes with a DECERR.
// Optional feature macro AXI_AW_DECERR_COUNT_EN adds a saturating DECERR counter.
module axi_aw_decoder_dest_push
    import axi_node_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int N_INIT_PORT  = 4,
    parameter int N_REGION     = 2,
    parameter int AXI_ID_WIDTH = 6,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    awvalid_i,
    input  logic [ADDR_WIDTH-1:0]                   awaddr_i,
    input  logic [AXI_ID_WIDTH-1:0]                 awid_i,
    output logic                                    awready_o,
    output logic [N_INIT_PORT-1:0]                  awvalid_o,
    input  logic [N_INIT_PORT-1:0]                  awready_i,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] START_ADDR_i,
    input  logic [N_REGION*N_INIT_PORT*ADDR_WIDTH-1:0] END_ADDR_i,
    input  logic [N_REGION*N_INIT_PORT-1:0]         enable_region_i,
    input  logic [N_INIT_PORT-1:0]                  connectivity_map_i,
    output logic [N_INIT_PORT-1:0]                  DEST_o,
    output logic                                    push_DEST_o,
    input  logic                                    grant_FIFO_DEST_i,
    input  logic                                    w_pop_i,
    output logic                                    handle_error_o,
    input  logic                                    wdata_error_completed_i,
    output logic                                    error_bvalid_o,
    output logic [AXI_ID_WIDTH-1:0]                 error_bid_o,
    output logic [1:0]                              error_bresp_o,
    input  logic                                    error_bready_i
`ifdef AXI_AW_DECERR_COUNT_EN
    ,
    output logic [15:0]                             decerr_count_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    aw_dec_state_t state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;

    logic [N_INIT_PORT-1:0]                         match;
    logic [N_INIT_PORT-1:0]                         dest_onehot;
    logic [N_INIT_PORT-1:0][N_REGION*ADDR_WIDTH-1:0] port_start;
    logic [N_INIT_PORT-1:0][N_REGION*ADDR_WIDTH-1:0] port_end;
    logic [N_INIT_PORT-1:0][N_REGION-1:0]           port_en;

    logic aw_ready;
    logic push;
    logic miss_accept;

    // The flat region vectors are ordered region-major; regroup them per port.
    for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_port
        for (genvar r = 0; r < N_REGION; r++) begin : g_region
            assign port_start[p][r*ADDR_WIDTH +: ADDR_WIDTH] =
                START_ADDR_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_end[p][r*ADDR_WIDTH +: ADDR_WIDTH] =
                END_ADDR_i[(r*N_INIT_PORT+p)*ADDR_WIDTH +: ADDR_WIDTH];
            assign port_en[p][r] = enable_region_i[r*N_INIT_PORT+p];
        end

        axi_region_match #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .N_REGION   (N_REGION)
        ) u_match (
            .addr_i          (awaddr_i),
            .start_addr_i    (port_start[p]),
            .end_addr_i      (port_end[p]),
            .enable_region_i (port_en[p]),
            .connected_i     (connectivity_map_i[p]),
            .match_o         (match[p])
        );
    end

    // Overlapping regions resolve to the lowest-numbered port.
    always_comb begin
        dest_onehot = '0;
        for (int p = N_INIT_PORT - 1; p >= 0; p--) begin
            if (match[p]) begin
                dest_onehot    = '0;
                dest_onehot[p] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        aw_ready       = 1'b0;
        push           = 1'b0;
        miss_accept    = 1'b0;
        awvalid_o      = '0;
        DEST_o         = '0;
        handle_error_o = 1'b0;
        error_bvalid_o = 1'b0;
        error_bid_o    = '0;

        unique case (state_q)
            IDLE: begin
                DEST_o = dest_onehot;
                if (dest_onehot != '0) begin
                    awvalid_o = dest_onehot & {N_INIT_PORT{awvalid_i & grant_FIFO_DEST_i}};
                    aw_ready  = (|(awready_i & dest_onehot)) & grant_FIFO_DEST_i;
                    push      = awvalid_i & aw_ready;
                end else if (awvalid_i) begin
                    aw_ready    = 1'b1;
                    miss_accept = 1'b1;
                    id_d        = awid_i;
                    state_d     = (cnt_q != '0) ? ERR_DRAIN : ERR_DATA;
                end
            end
            ERR_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ERR_DATA;
                end
            end
            ERR_DATA: begin
                handle_error_o = 1'b1;
                if (wdata_error_completed_i) begin
                    state_d = ERR_RESP;
                end
            end
            ERR_RESP: begin
                error_bvalid_o = 1'b1;
                error_bid_o    = id_q;
                if (error_bready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bursts whose destination was pushed but whose wlast has not yet been popped.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !w_pop_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && w_pop_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    assign awready_o     = aw_ready;
    assign push_DEST_o   = push;
    assign error_bresp_o = RESP_DECERR;

`ifdef AXI_AW_DECERR_COUNT_EN
    logic [15:0] decerr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decerr_cnt_q <= '0;
        end else if (miss_accept && (decerr_cnt_q != 16'hFFFF)) begin
            decerr_cnt_q <= decerr_cnt_q + 16'd1;
        end
    end

    assign decerr_count_o = decerr_cnt_q;
`else
`endif

    a_no_pop_underflow: assert property (
        @(posedge clk) disable iff (rst) !(w_pop_i && (cnt_q == '0))
    );

endmodule

// File: tb/tb_axi_aw_decoder_dest_push.sv
// Self-checking bench for axi_aw_decoder_dest_push: directed vector table,
// hand-written error-flow sequences, and a randomized run against a reference model.
module tb_axi_aw_decoder_dest_push;

    localparam int AW  = 32;
    localparam int NP  = 4;
    localparam int NR  = 2;
    localparam int IDW = 6;
    localparam int FD  = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  awvalid_i;
    logic [AW-1:0]         awaddr_i;
    logic [IDW-1:0]        awid_i;
    logic                  awready_o;
    logic [NP-1:0]         awvalid_o;
    logic [NP-1:0]         awready_i;
    logic [NR*NP*AW-1:0]   START_ADDR_i;
    logic [NR*NP*AW-1:0]   END_ADDR_i;
    logic [NR*NP-1:0]      enable_region_i;
    logic [NP-1:0]         connectivity_map_i;
    logic [NP-1:0]         DEST_o;
    logic                  push_DEST_o;
    logic                  grant_FIFO_DEST_i;
    logic                  w_pop_i;
    logic                  handle_error_o;
    logic                  wdata_error_completed_i;
    logic                  error_bvalid_o;
    logic [IDW-1:0]        error_bid_o;
    logic [1:0]            error_bresp_o;
    logic                  error_bready_i;
`ifdef AXI_AW_DECERR_COUNT_EN
    logic [15:0]           decerr_count_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] regStart [NP][NR];
    logic [AW-1:0] regEnd   [NP][NR];
    bit            regEn    [NP][NR];

    typedef struct {
        logic          awvalid;
        logic [AW-1:0] addr;
        logic [NP-1:0] awreadyIn;
        logic          grant;
        logic [NP-1:0] conn;
        logic [NP-1:0] expAwvalid;
        logic          expAwready;
        logic [NP-1:0] expDest;
        logic          expPush;
    } vec_t;

    vec_t vecs [10];

    axi_aw_decoder_dest_push #(
        .ADDR_WIDTH   (AW),
        .N_INIT_PORT  (NP),
        .N_REGION     (NR),
        .AXI_ID_WIDTH (IDW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .awvalid_i               (awvalid_i),
        .awaddr_i                (awaddr_i),
        .awid_i                  (awid_i),
        .awready_o               (awready_o),
        .awvalid_o               (awvalid_o),
        .awready_i               (awready_i),
        .START_ADDR_i            (START_ADDR_i),
        .END_ADDR_i              (END_ADDR_i),
        .enable_region_i         (enable_region_i),
        .connectivity_map_i      (connectivity_map_i),
        .DEST_o                  (DEST_o),
        .push_DEST_o             (push_DEST_o),
        .grant_FIFO_DEST_i       (grant_FIFO_DEST_i),
        .w_pop_i                 (w_pop_i),
        .handle_error_o          (handle_error_o),
        .wdata_error_completed_i (wdata_error_completed_i),
        .error_bvalid_o          (error_bvalid_o),
        .error_bid_o             (error_bid_o),
        .error_bresp_o           (error_bresp_o),
        .error_bready_i          (error_bready_i)
`ifdef AXI_AW_DECERR_COUNT_EN
        ,
        .decerr_count_o          (decerr_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        awvalid_i          = v.awvalid;
        awaddr_i           = v.addr;
        awready_i          = v.awreadyIn;
        grant_FIFO_DEST_i  = v.grant;
        connectivity_map_i = v.conn;
    endtask

    function automatic vec_t mkVec(logic awv, logic [AW-1:0] addr, logic [NP-1:0] rdy,
                                   logic grant, logic [NP-1:0] conn, logic [NP-1:0] eAwv,
                                   logic eRdy, logic [NP-1:0] eDest, logic ePush);
        vec_t v;
        v.awvalid = awv;   v.addr = addr;   v.awreadyIn = rdy;
        v.grant = grant;   v.conn = conn;   v.expAwvalid = eAwv;
        v.expAwready = eRdy; v.expDest = eDest; v.expPush = ePush;
        return v;
    endfunction

    task automatic setRegion(input int p, input int r, input logic [AW-1:0] s,
                             input logic [AW-1:0] e, input bit en);
        regStart[p][r] = s;
        regEnd[p][r]   = e;
        regEn[p][r]    = en;
        START_ADDR_i[(r*NP+p)*AW +: AW] = s;
        END_ADDR_i[(r*NP+p)*AW +: AW]   = e;
        enable_region_i[r*NP+p]         = en;
    endtask

    // Reference destination: first reachable port with an enabled region containing addr.
    function automatic logic [NP-1:0] refDest(logic [AW-1:0] addr, logic [NP-1:0] conn);
        for (int p = 0; p < NP; p++) begin
            if (conn[p]) begin
                for (int r = 0; r < NR; r++) begin
                    if (regEn[p][r] && addr >= regStart[p][r] && addr <= regEnd[p][r]) begin
                        return NP'(1) << p;
                    end
                end
            end
        end
        return '0;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idleInputs();
        awvalid_i = 1'b0; awaddr_i = '0; awid_i = '0; awready_i = '0;
        grant_FIFO_DEST_i = 1'b1; connectivity_map_i = '1; w_pop_i = 1'b0;
        wdata_error_completed_i = 1'b0; error_bready_i = 1'b0;
    endtask

    task automatic waitForHandle(input int maxCycles);
        int n = 0;
        while (handle_error_o !== 1'b1 && n < maxCycles) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (handle_error_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait handle_error_o: got %b expected 1 within %0d cycles",
                     handle_error_o, maxCycles);
        end
    endtask

    task automatic driveHit(input logic [AW-1:0] addr, input logic [NP-1:0] rdy);
        awvalid_i = 1'b1; awaddr_i = addr; awready_i = rdy; grant_FIFO_DEST_i = 1'b1;
    endtask

    function automatic logic [AW-1:0] pickAddr();
        int p = $urandom_range(0, NP-1);
        int r = $urandom_range(0, NR-1);
        if ($urandom_range(0, 3) == 0 || !regEn[p][r]) return AW'($urandom);
        return regStart[p][r] + AW'($urandom % (regEnd[p][r] - regStart[p][r] + 1));
    endfunction

    initial begin
        int outstanding;
        int phase;
        int missCount;
        logic [IDW-1:0] errId;
        logic [NP-1:0]  eDest, eAwv, eDestOut;
        logic           eRdy, ePush;

        rst = 1'b1;
        START_ADDR_i = '0; END_ADDR_i = '0; enable_region_i = '0;
        idleInputs();
        setRegion(0, 0, 32'h0000_0000, 32'h0000_0FFF, 1);
        setRegion(0, 1, 32'h0001_0000, 32'h0001_FFFF, 1);
        setRegion(1, 0, 32'h0000_3000, 32'h0000_3FFF, 1);
        setRegion(1, 1, 32'h0000_2000, 32'h0000_2FFF, 1);
        setRegion(2, 0, 32'h0000_1000, 32'h0000_1FFF, 1);
        setRegion(2, 1, 32'h4000_0000, 32'h4FFF_FFFF, 1);
        setRegion(3, 0, 32'h0000_2000, 32'h0000_20FF, 1);
        setRegion(3, 1, 32'h0000_8000, 32'h0000_FFFF, 0);

        // Reset state while reset is held
        #2;
        checkOutput("reset awready_o",  32'(awready_o), 0);
        checkOutput("reset awvalid_o",  32'(awvalid_o), 0);
        checkOutput("reset push",       32'(push_DEST_o), 0);
        checkOutput("reset handle",     32'(handle_error_o), 0);
        checkOutput("reset bvalid",     32'(error_bvalid_o), 0);
        checkOutput("reset bid",        32'(error_bid_o), 0);
        checkOutput("reset bresp",      32'(error_bresp_o), 3);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = mkVec(1, 32'h1800, 4'b0100, 1, 4'hF, 4'b0100, 1, 4'b0100, 1);
        vecs[1] = mkVec(1, 32'h1800, 4'b0000, 1, 4'hF, 4'b0100, 0, 4'b0100, 0);
        vecs[2] = mkVec(1, 32'h1800, 4'b0100, 0, 4'hF, 4'b0000, 0, 4'b0100, 0);
        vecs[3] = mkVec(1, 32'h2000, 4'b1010, 1, 4'hF, 4'b0010, 1, 4'b0010, 1);
        vecs[4] = mkVec(1, 32'h2000, 4'b1010, 1, 4'b1101, 4'b1000, 1, 4'b1000, 1);
        vecs[5] = mkVec(0, 32'h1800, 4'b0100, 1, 4'hF, 4'b0000, 1, 4'b0100, 0);
        vecs[6] = mkVec(1, 32'h0FFF, 4'b0001, 1, 4'hF, 4'b0001, 1, 4'b0001, 1);
        vecs[7] = mkVec(1, 32'h1000, 4'b0100, 1, 4'hF, 4'b0100, 1, 4'b0100, 1);
        vecs[8] = mkVec(0, 32'h9000, 4'b1111, 1, 4'hF, 4'b0000, 0, 4'b0000, 0);
        vecs[9] = mkVec(0, 32'h1FFF, 4'b1111, 1, 4'b1011, 4'b0000, 0, 4'b0000, 0);

        // Vectors are applied and withdrawn within one low phase so no edge sees them.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d awvalid_o", i), 32'(awvalid_o), 32'(vecs[i].expAwvalid));
            checkOutput($sformatf("vec%0d awready_o", i), 32'(awready_o), 32'(vecs[i].expAwready));
            checkOutput($sformatf("vec%0d DEST_o", i),    32'(DEST_o),    32'(vecs[i].expDest));
            checkOutput($sformatf("vec%0d push", i),      32'(push_DEST_o), 32'(vecs[i].expPush));
            #1;
            idleInputs();
        end

        // FIFO full, then grant returns
        @(negedge clk);
        driveHit(32'h1800, 4'b0100);
        grant_FIFO_DEST_i = 1'b0;
        #1;
        checkOutput("full awvalid_o", 32'(awvalid_o), 0);
        checkOutput("full awready_o", 32'(awready_o), 0);
        checkOutput("full push",      32'(push_DEST_o), 0);
        @(negedge clk);
        grant_FIFO_DEST_i = 1'b1;
        #1;
        checkOutput("grant awvalid_o", 32'(awvalid_o), 32'h4);
        checkOutput("grant awready_o", 32'(awready_o), 1);
        checkOutput("grant push",      32'(push_DEST_o), 1);
        @(negedge clk);
        idleInputs();
        w_pop_i = 1'b1;
        @(negedge clk);
        w_pop_i = 1'b0;

        // Miss with two outstanding bursts
        @(negedge clk);
        driveHit(32'h1800, 4'b0100);
        repeat (2) @(negedge clk);
        awaddr_i = 32'h9000;
        awid_i   = 6'd5;
        #1;
        checkOutput("miss awready_o", 32'(awready_o), 1);
        checkOutput("miss awvalid_o", 32'(awvalid_o), 0);
        checkOutput("miss push",      32'(push_DEST_o), 0);
        @(negedge clk);
        driveHit(32'h1800, 4'b0100);
        awid_i = 6'd0;
        #1;
        checkOutput("drain awready_o", 32'(awready_o), 0);
        checkOutput("drain push",      32'(push_DEST_o), 0);
        checkOutput("drain handle",    32'(handle_error_o), 0);
        @(negedge clk);
        idleInputs();
        w_pop_i = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("drain1 handle", 32'(handle_error_o), 0);
        @(negedge clk);
        w_pop_i = 1'b0;
        #1;
        waitForHandle(5);
        checkOutput("data bvalid", 32'(error_bvalid_o), 0);
        @(negedge clk);
        wdata_error_completed_i = 1'b1;
        @(negedge clk);
        wdata_error_completed_i = 1'b0;
        driveHit(32'h1800, 4'b0100);
        error_bready_i = 1'b1;
        #1;
        checkOutput("resp bvalid",    32'(error_bvalid_o), 1);
        checkOutput("resp bid",       32'(error_bid_o), 5);
        checkOutput("resp bresp",     32'(error_bresp_o), 3);
        checkOutput("resp handle",    32'(handle_error_o), 0);
        checkOutput("resp awready_o", 32'(awready_o), 0);
        @(negedge clk);
        error_bready_i = 1'b0;
        #1;
        checkOutput("after resp awready_o", 32'(awready_o), 1);
        checkOutput("after resp push",      32'(push_DEST_o), 1);
        checkOutput("after resp bvalid",    32'(error_bvalid_o), 0);
        @(negedge clk);
        idleInputs();
        w_pop_i = 1'b1;
        @(negedge clk);
        w_pop_i = 1'b0;

        // Connectivity mask turns a region hit into a miss
        @(negedge clk);
        driveHit(32'h0800, 4'b0001);
        connectivity_map_i = 4'b1110;
        awid_i = 6'h2A;
        #1;
        checkOutput("mask DEST_o",    32'(DEST_o), 0);
        checkOutput("mask awready_o", 32'(awready_o), 1);
        checkOutput("mask awvalid_o", 32'(awvalid_o), 0);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("mask handle", 32'(handle_error_o), 1);
        @(negedge clk);
        wdata_error_completed_i = 1'b1;
        @(negedge clk);
        wdata_error_completed_i = 1'b0;
        #1;
        checkOutput("mask bvalid", 32'(error_bvalid_o), 1);
        checkOutput("mask bid",    32'(error_bid_o), 32'h2A);
        @(negedge clk);
        error_bready_i = 1'b1;
        @(negedge clk);
        error_bready_i = 1'b0;

        // Reset during drain clears the outstanding count; reset in ERR_DATA is immediate
        driveHit(32'h1800, 4'b0100);
        repeat (2) @(negedge clk);
        awaddr_i = 32'h9000;
        @(negedge clk);
        idleInputs();
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        awaddr_i = 32'h0800;
        awready_i = 4'b0001;
        #1;
        checkOutput("post rst idle awready_o", 32'(awready_o), 1);
        checkOutput("post rst idle DEST_o",    32'(DEST_o), 1);
        @(negedge clk);
        awvalid_i = 1'b1;
        awaddr_i  = 32'h9000;
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("post rst count zero handle", 32'(handle_error_o), 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst handle", 32'(handle_error_o), 0);
        checkOutput("async rst bvalid", 32'(error_bvalid_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("after async rst handle", 32'(handle_error_o), 0);

        // Randomized run against the reference model
        doReset();
        outstanding = 0;
        phase       = 0;
        missCount   = 0;
        errId       = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            awvalid_i               = ($urandom_range(0, 9) < 7);
            awaddr_i                = pickAddr();
            awid_i                  = IDW'($urandom);
            awready_i               = NP'($urandom);
            grant_FIFO_DEST_i       = (outstanding < FD) && ($urandom_range(0, 4) != 0);
            connectivity_map_i      = ($urandom_range(0, 4) == 0) ? NP'($urandom) : '1;
            w_pop_i                 = (outstanding > 0) && ($urandom_range(0, 9) < 4);
            wdata_error_completed_i = ($urandom_range(0, 9) < 3);
            error_bready_i          = 1'($urandom_range(0, 1));
            #1;

            eDest = refDest(awaddr_i, connectivity_map_i);
            eDestOut = '0; eAwv = '0; eRdy = 1'b0; ePush = 1'b0;
            if (phase == 0) begin
                eDestOut = eDest;
                if (eDest != '0) begin
                    eRdy  = ((awready_i & eDest) != '0) && grant_FIFO_DEST_i;
                    eAwv  = (awvalid_i && grant_FIFO_DEST_i) ? eDest : '0;
                    ePush = awvalid_i && eRdy;
                end else begin
                    eRdy = awvalid_i;
                end
            end

            checkOutput("rnd awvalid_o", 32'(awvalid_o), 32'(eAwv));
            checkOutput("rnd awready_o", 32'(awready_o), 32'(eRdy));
            checkOutput("rnd DEST_o",    32'(DEST_o),    32'(eDestOut));
            checkOutput("rnd push",      32'(push_DEST_o), 32'(ePush));
            checkOutput("rnd handle",    32'(handle_error_o), 32'(phase == 2));
            checkOutput("rnd bvalid",    32'(error_bvalid_o), 32'(phase == 3));
            checkOutput("rnd bid",       32'(error_bid_o), (phase == 3) ? 32'(errId) : 0);
            checkOutput("rnd bresp",     32'(error_bresp_o), 3);
`ifdef AXI_AW_DECERR_COUNT_EN
            checkOutput("rnd decerr count", 32'(decerr_count_o), 32'(missCount));
`endif

            case (phase)
                0: if (eDest == '0 && awvalid_i) begin
                    errId = awid_i;
                    phase = (outstanding != 0) ? 1 : 2;
                    if (missCount < 65535) missCount++;
                end
                1: if (outstanding == 0) phase = 2;
                2: if (wdata_error_completed_i) phase = 3;
                default: if (error_bready_i) phase = 0;
            endcase
            outstanding = outstanding + int'(ePush) - int'(w_pop_i);
        end

        @(negedge clk);
        idleInputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/axi_aw_decoder_dest_push.md
Name: axi_aw_decoder_dest_push

Overview:
- Write-address-channel decoder for one AXI slave port of the node. It sits directly upstream of the write-data decoder.
- Matches AWADDR against per-master-port address regions and steers AWVALID/AWREADY to the selected master port.
- Pushes the one-hot destination into the write-data decoder's destination FIFO.
- Unmapped addresses are absorbed: it drains outstanding write data, flags error handling, then returns a DECERR write response.

Parameters:
- ADDR_WIDTH, 32, AW address width.
- N_INIT_PORT, 4, number of master (initiator-side) ports; one-hot destination width.
- N_REGION, 2, address regions per master port.
- AXI_ID_WIDTH, 6, AWID/BID width.
- FIFO_DEPTH, 8, depth of downstream destination FIFO; sizes the outstanding counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- awvalid_i  in  1  slave AW valid
- awaddr_i  in  ADDR_WIDTH  slave AW address
- awid_i  in  AXI_ID_WIDTH  slave AW id
- awready_o  out  1  slave AW ready
- awvalid_o  out  N_INIT_PORT  per-master AW valid
- awready_i  in  N_INIT_PORT  per-master AW ready
- START_ADDR_i  in  N_REGION*N_INIT_PORT*ADDR_WIDTH  region start, inclusive
- END_ADDR_i  in  N_REGION*N_INIT_PORT*ADDR_WIDTH  region end, inclusive
- enable_region_i  in  N_REGION*N_INIT_PORT  region enables
- connectivity_map_i  in  N_INIT_PORT  master ports reachable from this slave
- DEST_o  out  N_INIT_PORT  one-hot destination to FIFO
- push_DEST_o  out  1  FIFO push
- grant_FIFO_DEST_i  in  1  FIFO not full
- w_pop_i  in  1  pulse when downstream pops a FIFO entry (wlast beat accepted)
- handle_error_o  out  1  downstream sinks W data for the errored burst
- wdata_error_completed_i  in  1  errored burst's wlast sunk
- error_bvalid_o  out  1  DECERR B valid
- error_bid_o  out  AXI_ID_WIDTH  DECERR B id
- error_bresp_o  out  2  constant DECERR (2'b11)
- error_bready_i  in  1  B ready

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: FSM=IDLE, outstanding count=0, latched id=0. All outputs 0 except error_bresp_o, which is constant 2'b11.
- Match:
  - match[p] = connectivity_map_i[p] & OR over regions r of (enable_region_i[r][p] & START<=awaddr_i<=END), unsigned.
  - Multiple hits resolve to the lowest p, so DEST_o is always one-hot or zero.
- IDLE, hit (DEST_o != 0):
  - awvalid_o = DEST_o gated by awvalid_i & grant_FIFO_DEST_i.
  - awready_o = |(awready_i & DEST_o) & grant_FIFO_DEST_i.
  - push_DEST_o = awvalid_i & awready_o. Zero added latency (combinational).
- IDLE, miss with awvalid_i:
  - awready_o=1, awvalid_o=0, no push.
  - Latch awid_i. Next state is ERR_DRAIN if the count is nonzero, else ERR_DATA.
- ERR_DRAIN: awready_o=0; wait until the count reaches 0, then go to ERR_DATA.
- ERR_DATA: handle_error_o=1, awready_o=0. On wdata_error_completed_i go to ERR_RESP.
- ERR_RESP:
  - error_bvalid_o=1, error_bid_o = latched id.
  - On error_bready_i go to IDLE; the next AW can be accepted in the following cycle, not the same one.
- Outstanding counter:
  - Width $clog2(FIFO_DEPTH+1). +1 on push, -1 on w_pop_i; push and pop together leave it unchanged.
  - Saturation never occurs because push is gated by grant_FIFO_DEST_i.
  - A pop when the count is 0 is a protocol violation and is flagged by an assertion.
- awvalid_i dropping without a handshake is tolerated; outputs follow combinationally.
- Reset mid-error returns to IDLE immediately and de-asserts handle_error_o and error_bvalid_o.

Optional Feature:
- AXI_AW_DECERR_COUNT_EN: adds output decerr_count_o [15:0].
  - Increments on each accepted miss and saturates at 16'hFFFF.
  - Cleared by rst.
- Without the macro, the port and counter do not exist.

Decomposition:
- Shared package axi_node_pkg holds:
  - constants RESP_DECERR=2'b11, RESP_OKAY=2'b00;
  - enum aw_dec_state_t {IDLE, ERR_DRAIN, ERR_DATA, ERR_RESP}.
- One sub-module, axi_region_match: per master port, N_REGION comparators producing match[p]; instantiated N_INIT_PORT times.

Test Plan:
- Hit: region0 port2 = 0x1000-0x1FFF, AW 0x1800.
  - Expect awvalid_o=4'b0100.
  - awready_i[2]=1 gives awready_o=1, push_DEST_o=1, DEST_o=4'b0100.
- FIFO full: grant_FIFO_DEST_i=0, AW hit → awvalid_o=0, awready_o=0, no push. Grant returns → handshake completes in the same cycle.
- Overlap: ports 1 and 3 both match 0x2000 → DEST_o=4'b0010.
- Miss with 2 outstanding, AWID=5:
  - Awready pulses, state ERR_DRAIN.
  - Two w_pop_i pulses → ERR_DATA with handle_error_o=1.
  - wdata_error_completed_i → error_bvalid_o=1, bid=5, bresp=3.
  - bready → IDLE.
- Connectivity mask: address in port 0 region but connectivity_map_i[0]=0 → treated as miss, DECERR.
- Reset asserted in ERR_DATA → handle_error_o=0 asynchronously, count=0, FSM=IDLE.
